// File: rtl/mlp_neuron_sequencer.sv
// ============================================================================
// Module   : mlp_neuron_sequencer
// Purpose  : Runs one neuron MAC datapath through NUM_LAYERS passes per job,
//            capturing the neuron output at the end of every pass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlp_neuron_sequencer #(
  parameter int NEURON_WIDTH = 3,
  parameter int PIPE_LAT     = 3,
  parameter int NUM_LAYERS   = 2,
  parameter int LAYER_BITS   = 1,
  parameter int OUT_BITS     = 24
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NUM_LAYERS-1:0]      act_cfg,
  output logic [31:0]                counter,
  output logic                       activation_function,
  output logic [LAYER_BITS-1:0]      layer_idx,
  input  logic signed [OUT_BITS-1:0] neuron_out,
  output logic signed [OUT_BITS-1:0] result,
  output logic [LAYER_BITS-1:0]      result_layer,
  output logic                       result_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int c_LAST     = NEURON_WIDTH + PIPE_LAT;
  localparam int c_CNT_BITS = (c_LAST < 1) ? 1 : $clog2(c_LAST + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [c_CNT_BITS-1:0]   r_cnt, w_cnt_nxt;
  logic [LAYER_BITS-1:0]   r_layer, w_layer_nxt, w_layer_inc;
  logic [NUM_LAYERS-1:0]   r_snap, w_snap_nxt;
  logic                    r_act, w_act_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_rv, w_rv_nxt;
  logic                    w_capture;
  logic signed [OUT_BITS-1:0] r_result;
  logic [LAYER_BITS-1:0]   r_result_layer;

  assign w_layer_inc = r_layer + LAYER_BITS'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_layer        <= '0;
      r_snap         <= '0;
      r_act          <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_rv           <= 1'b0;
      r_result       <= '0;
      r_result_layer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_layer <= w_layer_nxt;
      r_snap  <= w_snap_nxt;
      r_act   <= w_act_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rv    <= w_rv_nxt;
      if (w_capture) begin
        r_result       <= neuron_out;
        r_result_layer <= r_layer;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_layer_nxt = r_layer;
    w_snap_nxt  = r_snap;
    w_act_nxt   = r_act;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_rv_nxt    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt   = '0;
        w_layer_nxt = '0;
        w_busy_nxt  = 1'b0;
        if (start && !abort) begin
          w_snap_nxt  = act_cfg;
          w_act_nxt   = act_cfg[0];
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins even on the capture edge: nothing is reported.
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_layer_nxt = '0;
          w_busy_nxt  = 1'b0;
        end else if (r_cnt < c_CNT_BITS'(c_LAST)) begin
          w_cnt_nxt = r_cnt + c_CNT_BITS'(1);
        end else begin
          w_capture = 1'b1;
          w_rv_nxt  = 1'b1;
          w_cnt_nxt = '0;
          if (r_layer < LAYER_BITS'(NUM_LAYERS - 1)) begin
            w_layer_nxt = w_layer_inc;
            w_act_nxt   = r_snap[w_layer_inc];
          end else begin
            w_layer_nxt = '0;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign counter             = 32'(r_cnt);
  assign activation_function = r_act;
  assign layer_idx           = r_layer;
  assign result              = r_result;
  assign result_layer        = r_result_layer;
  assign result_valid        = r_rv;
  assign busy                = r_busy;
  assign done                = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mlp_neuron_sequencer.sv
// ============================================================================
// Module   : tb_mlp_neuron_sequencer
// Purpose  : Directed jobs with a capture scoreboard for mlp_neuron_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mlp_neuron_sequencer;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [1:0]         act_cfg = 2'b00;
  logic [31:0]        counter;
  logic               activation_function;
  logic [0:0]         layer_idx;
  logic signed [23:0] neuron_out = 24'sd1234;
  logic signed [23:0] result;
  logic [0:0]         result_layer;
  logic               result_valid;
  logic               busy;
  logic               done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int res;
    int layer;
    int dn;
    int at;
  } exp_t;

  exp_t sb[$];

  mlp_neuron_sequencer #(
    .NEURON_WIDTH(3), .PIPE_LAT(3), .NUM_LAYERS(2), .LAYER_BITS(1), .OUT_BITS(24)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .act_cfg(act_cfg),
    .counter(counter), .activation_function(activation_function),
    .layer_idx(layer_idx), .neuron_out(neuron_out), .result(result),
    .result_layer(result_layer), .result_valid(result_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every capture pulse is matched against the next expected entry.
  always @(negedge clk) begin
    if (rstn) begin
      if (result_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL capture: got unexpected result=%0d layer=%0d at cycle %0d required none",
                   result, result_layer, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (int'(result) != e.res || int'(result_layer) != e.layer ||
              int'(done) != e.dn || cyc != e.at) begin
            errors++;
            $display("FAIL capture: got result=%0d layer=%0d done=%0d cycle=%0d required result=%0d layer=%0d done=%0d cycle=%0d",
                     result, result_layer, done, cyc, e.res, e.layer, e.dn, e.at);
          end
        end
      end else if (done) begin
        checks++;
        errors++;
        $display("FAIL done_alone: got done=1 without result_valid at cycle %0d required 0", cyc);
      end
    end
  end

  // mode 0 normal, 1 glitch -5 at layer-0 capture, 2 restart+cfg flip, 3 abort, 4 reset
  task automatic run_job(input logic [1:0] cfg, input int mode);
    int e0;
    exp_t e;
    @(negedge clk);
    act_cfg = cfg;
    start = 1'b1;
    abort = 1'b0;
    neuron_out = 24'sd1234;
    e0 = cyc + 1;
    if (mode != 4) begin
      e.res = (mode == 1) ? -5 : 1234; e.layer = 0; e.dn = 0; e.at = e0 + 7;
      sb.push_back(e);
    end
    if (mode <= 2) begin
      e.res = 1234; e.layer = 1; e.dn = 1; e.at = e0 + 14;
      sb.push_back(e);
    end
    for (int j = 0; j <= 14; j++) begin
      @(negedge clk);
      if (mode == 3 && j == 10) begin
        chk("abort_busy", int'(busy), 0);
        chk("abort_counter", int'(counter), 0);
        chk("abort_layer", int'(layer_idx), 0);
        chk("abort_result", int'(result), 1234);
        chk("abort_result_layer", int'(result_layer), 0);
        return;
      end else if (j < 14) begin
        chk("run_counter", int'(counter), j % 7);
        chk("run_layer", int'(layer_idx), j / 7);
        chk("run_act", int'(activation_function), int'(cfg[j / 7]));
        chk("run_busy", int'(busy), 1);
      end else begin
        chk("end_busy", int'(busy), 0);
        chk("end_counter", int'(counter), 0);
        chk("end_layer", int'(layer_idx), 0);
      end
      start = (mode == 2 && j == 2);
      if (mode == 2 && j == 3) act_cfg = 2'b01;
      neuron_out = (mode == 1 && j == 6) ? -24'sd5 : 24'sd1234;
      abort = (mode == 3 && j == 9);
      if (mode == 4 && j == 5) begin
        rstn = 1'b0;
        #1;
        chk("rst_counter", int'(counter), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_layer", int'(layer_idx), 0);
        chk("rst_act", int'(activation_function), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_result_layer", int'(result_layer), 0);
        chk("rst_valid_done", int'({result_valid, done}), 0);
        @(negedge clk);
        chk("rst_hold_busy", int'(busy), 0);
        rstn = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_counter", int'(counter), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_result", int'(result), 0);
    end

    run_job(2'b10, 0);
    run_job(2'b10, 1);
    chk("glitch_held_result", int'(result), 1234);
    run_job(2'b10, 2);

    // abort in IDLE blocks a simultaneous start
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);

    run_job(2'b10, 3);
    run_job(2'b10, 0);
    run_job(2'b11, 4);
    run_job(2'b01, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mlp_neuron_sequencer.md
Name: mlp_neuron_sequencer

Overview:
- Control FSM that drives the shared `counter` and `activation_function` inputs of the single-neuron MAC datapath.
- Time-multiplexes that datapath over NUM_LAYERS consecutive passes (one pass per layer).
- Captures the neuron output at the end of each pass and raises a start/busy/done handshake toward the top-level controller.
- Sits between the top-level controller and the neuron datapath, alongside the weight/bias bank muxes that `layer_idx` selects.

Parameters:
- NEURON_WIDTH, 3, index of the last input element; a pass feeds elements 0..NEURON_WIDTH.
- PIPE_LAT, 3, cycles after counter==NEURON_WIDTH until the neuron output is valid (register, multiplier, adder, activation stages).
- NUM_LAYERS, 2, passes per job; must be >= 1.
- LAYER_BITS, 1, width of `layer_idx`; must satisfy 2**LAYER_BITS >= NUM_LAYERS.
- OUT_BITS, 24, width of the neuron output (NEURON_BITS+9).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- start  input  1  job request; sampled only in IDLE.
- abort  input  1  synchronous cancel; takes priority over every other event except reset.
- act_cfg  input  NUM_LAYERS  per-layer activation select; bit i applies to layer i.
- counter  output  32  element index/phase to the neuron datapath.
- activation_function  output  1  activation select for the current layer.
- layer_idx  output  LAYER_BITS  current layer; selects the weight/bias bank.
- neuron_out  input  OUT_BITS (signed)  neuron datapath output.
- result  output  OUT_BITS (signed)  captured neuron output.
- result_layer  output  LAYER_BITS  layer that produced `result`.
- result_valid  output  1  one-cycle pulse on each capture.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse when the job completes.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE. The following outputs all clear to 0: `counter`, `layer_idx`, `activation_function`, `result`, `result_layer`, `result_valid`, `busy`, `done`, and the act_cfg snapshot.
- LAST = NEURON_WIDTH + PIPE_LAT. Each pass is LAST+1 cycles long.
- States are IDLE and RUN.
- IDLE:
  - `counter` holds at 0 and `busy` is 0.
  - On an edge with start=1 and abort=0: snapshot act_cfg, then set layer_idx=0, counter=0, busy=1, activation_function=act_cfg[0], and go to RUN.
- RUN, edge with counter < LAST: counter increments by 1.
- RUN, edge with counter == LAST:
  - Capture: result <= neuron_out, result_layer <= layer_idx, result_valid <= 1 for exactly one cycle.
  - If layer_idx < NUM_LAYERS-1: layer_idx increments, activation_function <= snapshot[layer_idx+1], counter <= 0, stay in RUN.
  - Else: done <= 1 for one cycle, busy <= 0, counter <= 0, layer_idx <= 0, go to IDLE.
  - `done` and the final `result_valid` assert in the same cycle.
- act_cfg changes during RUN have no effect; only the snapshot is used.
- start while busy: ignored, not queued. A start held high through done starts a new job on the first IDLE edge, one cycle after done.
- abort in RUN:
  - Next edge: go to IDLE with counter=0, layer_idx=0, busy=0.
  - No done pulse and no result_valid pulse, even if counter==LAST on that edge.
  - `result` and `result_layer` keep their previous values.
- abort in IDLE: no effect, and it blocks a simultaneous start.
- Reset mid-job: immediate return to the reset state; no done pulse.
- `result` holds its value between captures.
- `counter` never exceeds LAST. Upper bits above those needed to hold LAST are always 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (defaults: NEURON_WIDTH=3, PIPE_LAT=3, NUM_LAYERS=2, so LAST=6):
- Reset release, no start -> counter=0, busy=0, done=0, result=0 held for 20 cycles.
- start pulse at edge E0 with act_cfg=2'b10, neuron_out tied to 24'sd1234 ->
  - counter sequence 0..6,0..6.
  - activation_function 0 during layer 0, 1 during layer 1.
  - result_valid pulses at edges E0+7 (result_layer=0) and E0+14 (result_layer=1), with result=1234 each time.
  - done pulses at E0+14; busy high from E0 until E0+14.
- neuron_out driven to -5 only in the cycle where counter==6 of layer 0 -> result=-5, result_layer=0; no other value is captured.
- start re-asserted at E0+3 and act_cfg flipped to 2'b01 mid-job -> no restart; layer 1 still uses snapshot bit 1=1; single done at E0+14.
- abort at E0+9 (layer 1, counter=2) -> busy=0 and counter=0 at E0+10; no done pulse; result keeps layer-0 value; a new start at E0+12 runs a full job from layer 0.
- rstn low at E0+5 -> all outputs 0 immediately (asynchronous); after release, start runs a full 14-cycle job normally.
